mul_ctrl: RTL and testbench
===========================

// Module: mul_ctrl
// PURPOSE
//  Sequencing controller for the EX-stage combinational Multiplier. Accepts MULT/MULTU from EX,
//  latches operands, holds them stable for MUL_CYCLES cycles (multicycle path), samples the
//  64-bit product, applies the unsigned correction and writes HI/LO.
//  Stalls the pipeline from issue until writeback. Sits between EX decode, the Multiplier and the HI/LO register.
// PARAMETERS
//  MUL_CYCLES   3          cycles operands are held before the product is sampled; legal range >= 1
//  FUNCT_MULT   6'b011000  funct code for signed multiply
//  FUNCT_MULTU  6'b011001  funct code for unsigned multiply
// PORTS
//  clk         in   1   clock; all state updates on the rising edge
//  rst_n       in   1   asynchronous, active-low reset
//  start       in   1   EX holds a valid instruction
//  funct       in   6   funct field of the EX instruction
//  operand_1   in   32  rs value
//  operand_2   in   32  rt value
//  flush       in   1   pipeline flush; cancels any operation in flight
//  mul_en      out  1   enable to the Multiplier
//  mul_op1     out  32  latched operand 1 to the Multiplier
//  mul_op2     out  32  latched operand 2 to the Multiplier
//  mul_result  in   64  signed product from the Multiplier
//  stall_req   out  1   holds IF/ID/EX while a multiply is in progress
//  busy        out  1   state != IDLE
//  hilo_we     out  1   one-cycle HI/LO write strobe
//  hi_o        out  32  product [63:32]
//  lo_o        out  32  product [31:0]
// BEHAVIOUR
//  Reset (asynchronous, rst_n=0): state=IDLE, cnt=0, is_unsigned=0.
//   mul_op1, mul_op2, hi_o and lo_o are 0. mul_en, stall_req, busy and hilo_we are 0.
//   Reset takes effect immediately, including mid-operation; the in-flight op is lost.
//  accept = start & !flush & (funct==FUNCT_MULT | funct==FUNCT_MULTU).
//  States: IDLE, BUSY, DONE.
//   IDLE: accept -> latch mul_op1/mul_op2 and is_unsigned=(funct==FUNCT_MULTU);
//    cnt=MUL_CYCLES-1; next state BUSY. Non-multiply funct or start=0: stay in IDLE.
//   BUSY: mul_en=1. If cnt==0: capture the corrected product into hi_o/lo_o and go to DONE.
//    Otherwise decrement cnt. BUSY therefore lasts exactly MUL_CYCLES cycles.
//   DONE: hilo_we = !flush; next state IDLE.
//    start is ignored in DONE, because the same instruction is still in EX while it drains.
//  stall_req (combinational) = (state==IDLE & accept) | (state==BUSY & !flush).
//   stall_req is 0 in DONE.
//  Latency: accept in cycle 0; BUSY in cycles 1..MUL_CYCLES; DONE with hilo_we in cycle MUL_CYCLES+1.
//   stall_req is high in cycles 0..MUL_CYCLES, i.e. MUL_CYCLES+1 cycles.
//  Arithmetic: the Multiplier always returns the signed product P.
//   MULT:  {hi,lo} = P.
//   MULTU: lo = P[31:0]; hi = P[63:32] + (op1[31] ? op2 : 0) + (op2[31] ? op1 : 0), mod 2^32.
//  flush: in BUSY, drop stall_req in the same cycle, go to IDLE next cycle, no capture.
//   hi_o/lo_o keep their old values.
//   In DONE, flush suppresses hilo_we (hi_o/lo_o already updated, no write strobe).
//   In IDLE, flush blocks accept.
//  hi_o/lo_o hold their value until the next capture. mul_op1/mul_op2 hold their value after the op.
//  Simultaneous start+flush in IDLE: no accept, no stall.
// TESTING
//  (MUL_CYCLES=3 unless stated)
//  MULT 0xFFFFFFFE*0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA;
//   stall_req high 4 cycles; hilo_we single pulse in cycle 4.
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//   MULTU 0x80000000*2 -> 0x00000001_00000000. MULT of the same operands -> 0xFFFFFFFF_00000000.
//  MULT 5*7, flush asserted in the 2nd BUSY cycle -> stall_req=0 that cycle, IDLE next cycle,
//   no hilo_we, hi/lo unchanged.
//  rst_n=0 asynchronously mid-BUSY -> all outputs 0 before the next edge;
//   after release, MULT 2*3 completes -> lo=6.
//  start with funct=6'b100000 (ADD) -> stall_req=0, busy=0, no hilo_we.
//   start held through DONE -> exactly one hilo_we.
//  MUL_CYCLES=1: MULT 0x7FFFFFFF*0x7FFFFFFF -> 0x3FFFFFFF_00000001;
//   stall_req high 2 cycles, hilo_we in cycle 2.

Source files
------------

// File: rtl/mul_ctrl_if.sv
// Signal bundle between EX decode, the combinational Multiplier, HI/LO and the
// mul_ctrl sequencer. The controller uses the slave view; its environment uses master.
interface mul_ctrl_if;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        flush;
  logic        mul_en;
  logic [31:0] mul_op1;
  logic [31:0] mul_op2;
  logic [63:0] mul_result;
  logic        stall_req;
  logic        busy;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport slave (
    input  start, funct, operand_1, operand_2, flush, mul_result,
    output mul_en, mul_op1, mul_op2, stall_req, busy, hilo_we, hi_o, lo_o
  );

  modport master (
    output start, funct, operand_1, operand_2, flush, mul_result,
    input  mul_en, mul_op1, mul_op2, stall_req, busy, hilo_we, hi_o, lo_o
  );
endinterface

// File: rtl/mul_ctrl.sv
// Multicycle sequencer for the EX-stage Multiplier: holds operands for MUL_CYCLES,
// samples the signed product, fixes it up for MULTU and strobes the HI/LO write.
module mul_ctrl #(
  parameter int         MUL_CYCLES  = 3,
  parameter logic [5:0] FUNCT_MULT  = 6'b011000,
  parameter logic [5:0] FUNCT_MULTU = 6'b011001
) (
  input logic     clk,
  input logic     rst_n,
  mul_ctrl_if.slave bus
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_unsigned;
  logic [31:0]   op1;
  logic [31:0]   op2;
  logic [31:0]   hi;
  logic [31:0]   lo;

  logic        is_mul;
  logic        accept;
  logic [31:0] hi_fixed;

  assign is_mul = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_MULTU);
  assign accept = bus.start && !bus.flush && is_mul;

  // Reinterpreting a signed product as unsigned only changes the upper word.
  assign hi_fixed = bus.mul_result[63:32]
                  + (op1[31] ? op2 : 32'd0)
                  + (op2[31] ? op1 : 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      is_unsigned <= 1'b0;
      op1         <= '0;
      op2         <= '0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op1         <= bus.operand_1;
            op2         <= bus.operand_2;
            is_unsigned <= (bus.funct == FUNCT_MULTU);
            cnt         <= CW'(MUL_CYCLES - 1);
            state       <= BUSY;
          end
        end
        BUSY: begin
          // A flush abandons the op before capture so HI/LO keep their old contents.
          if (bus.flush) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            hi    <= is_unsigned ? hi_fixed : bus.mul_result[63:32];
            lo    <= bus.mul_result[31:0];
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mul_en    = (state == BUSY);
  assign bus.busy      = (state != IDLE);
  assign bus.stall_req = ((state == IDLE) && accept) || ((state == BUSY) && !bus.flush);
  assign bus.hilo_we   = (state == DONE) && !bus.flush;
  assign bus.mul_op1   = op1;
  assign bus.mul_op2   = op2;
  assign bus.hi_o      = hi;
  assign bus.lo_o      = lo;

endmodule

// File: tb/tb_mul_ctrl.sv
// Randomised bench for mul_ctrl: two instances (MUL_CYCLES=3 and 1) checked cycle by
// cycle against a per-operation reference computed with plain 64-bit arithmetic.
module tb_mul_ctrl;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start;
  logic        flush;
  logic [5:0]  funct;
  logic [31:0] opa;
  logic [31:0] opb;
  bit          sel;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_hi [2];
  logic [31:0] exp_lo [2];

  mul_ctrl_if bus3 ();
  mul_ctrl_if bus1 ();

  function automatic logic [63:0] signed_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Environment side of both controllers: shared EX inputs, one Multiplier each.
  assign bus3.start      = start;
  assign bus3.funct      = funct;
  assign bus3.operand_1  = opa;
  assign bus3.operand_2  = opb;
  assign bus3.flush      = flush;
  assign bus3.mul_result = signed_mul(bus3.mul_op1, bus3.mul_op2);
  assign bus1.start      = start;
  assign bus1.funct      = funct;
  assign bus1.operand_1  = opa;
  assign bus1.operand_2  = opb;
  assign bus1.flush      = flush;
  assign bus1.mul_result = signed_mul(bus1.mul_op1, bus1.mul_op2);

  mul_ctrl #(.MUL_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));
  mul_ctrl #(.MUL_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  logic        o_stall, o_busy, o_en, o_we;
  logic [31:0] o_op1, o_op2, o_hi, o_lo;
  assign o_stall = sel ? bus1.stall_req : bus3.stall_req;
  assign o_busy  = sel ? bus1.busy      : bus3.busy;
  assign o_en    = sel ? bus1.mul_en    : bus3.mul_en;
  assign o_we    = sel ? bus1.hilo_we   : bus3.hilo_we;
  assign o_op1   = sel ? bus1.mul_op1   : bus3.mul_op1;
  assign o_op2   = sel ? bus1.mul_op2   : bus3.mul_op2;
  assign o_hi    = sel ? bus1.hi_o      : bus3.hi_o;
  assign o_lo    = sel ? bus1.lo_o      : bus3.lo_o;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference 64-bit product straight from the operand interpretation.
  function automatic logic [63:0] ref_product(input logic [5:0] fn, input logic [31:0] a,
                                              input logic [31:0] b);
    logic [63:0] ua;
    logic [63:0] ub;
    if (fn == F_MULTU) begin
      ua = {32'd0, a};
      ub = {32'd0, b};
      return ua * ub;
    end
    return signed_mul(a, b);
  endfunction

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, " stall_req"}, o_stall, 0);
    checkOutput({tag, " busy"},      o_busy,  0);
    checkOutput({tag, " mul_en"},    o_en,    0);
    checkOutput({tag, " hilo_we"},   o_we,    0);
    checkOutput({tag, " mul_op1"},   o_op1,   0);
    checkOutput({tag, " mul_op2"},   o_op2,   0);
    checkOutput({tag, " hi_o"},      o_hi,    0);
    checkOutput({tag, " lo_o"},      o_lo,    0);
  endtask

  // One instruction presented in cycle 0; f is the cycle carrying a one-cycle flush (-1: none).
  task automatic applyStimulus(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                               input bit hold, input int f);
    int          mc;
    bit          acc;
    bit          aborted;
    bit          in_busy;
    bit          in_done;
    logic [63:0] p;
    mc      = sel ? 1 : 3;
    acc     = ((fn == F_MULT) || (fn == F_MULTU)) && (f != 0);
    aborted = 1'b0;
    p       = ref_product(fn, a, b);
    for (int k = 0; k <= mc + 2; k++) begin
      @(posedge clk);
      #1;
      start = (k == 0) || (hold && k <= mc + 1);
      flush = (k == f);
      funct = fn;
      opa   = a;
      opb   = b;
      @(negedge clk);
      in_busy = acc && !aborted && k >= 1 && k <= mc;
      in_done = acc && !aborted && k == mc + 1;
      if (in_done) begin
        exp_hi[sel] = p[63:32];
        exp_lo[sel] = p[31:0];
      end
      checkOutput("stall_req", o_stall, (k == 0 && acc) || (in_busy && k != f));
      checkOutput("busy",      o_busy,  in_busy || in_done);
      checkOutput("mul_en",    o_en,    in_busy);
      checkOutput("hilo_we",   o_we,    in_done && k != f);
      if (in_busy) begin
        checkOutput("mul_op1", o_op1, a);
        checkOutput("mul_op2", o_op2, b);
      end
      checkOutput("hi_o", o_hi, exp_hi[sel]);
      checkOutput("lo_o", o_lo, exp_lo[sel]);
      if (in_busy && k == f) aborted = 1'b1;
    end
    start = 1'b0;
    flush = 1'b0;
  endtask

  task automatic resetBoth();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkIdleZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_hi = '{32'd0, 32'd0};
    exp_lo = '{32'd0, 32'd0};
  endtask

  logic [5:0]  rfn;
  logic [31:0] ra;
  logic [31:0] rb;
  int          rf;
  bit          rhold;

  initial begin
    sel   = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    funct = '0;
    opa   = '0;
    opb   = '0;
    rst_n = 1'b0;
    exp_hi = '{32'd0, 32'd0};
    exp_lo = '{32'd0, 32'd0};
    #12;
    checkIdleZero("por");
    rst_n = 1'b1;

    applyStimulus(F_MULT,  32'hFFFFFFFE, 32'h00000003, 1'b0, -1);
    applyStimulus(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1);
    applyStimulus(F_MULTU, 32'h80000000, 32'h00000002, 1'b0, -1);
    applyStimulus(F_MULT,  32'h80000000, 32'h00000002, 1'b0, -1);
    applyStimulus(F_MULT,  32'd5,        32'd7,        1'b0, 2);
    applyStimulus(F_ADD,   32'd1,        32'd2,        1'b0, -1);
    applyStimulus(F_MULTU, 32'd11,       32'd13,       1'b1, -1);
    applyStimulus(F_MULT,  32'd4,        32'd9,        1'b0, 4);
    applyStimulus(F_MULT,  32'd4,        32'd9,        1'b0, 0);

    // Asynchronous reset in the middle of a BUSY phase, then a fresh op.
    @(posedge clk);
    #1 start = 1'b1; funct = F_MULT; opa = 32'd9; opb = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    resetBoth();
    applyStimulus(F_MULT, 32'd2, 32'd3, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       rfn = F_MULT;
        1:       rfn = F_MULTU;
        2:       rfn = F_ADD;
        default: rfn = 6'($urandom);
      endcase
      ra    = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      rb    = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      rf    = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 4));
      rhold = (rf < 0) && ($urandom_range(0, 1) == 1);
      applyStimulus(rfn, ra, rb, rhold, rf);
    end

    repeat (4) @(posedge clk);
    resetBoth();
    sel = 1'b1;
    applyStimulus(F_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, -1);
    applyStimulus(F_MULTU, 32'hFFFFFFFF, 32'h00000002, 1'b1, -1);
    applyStimulus(F_MULT,  32'd3,        32'd3,        1'b0, 1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
